// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) sequencer
// sharing one external WIDTH-bit adder. Optional MULTDIV_REM_EN adds a signed remainder output.
module multdiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef MULTDIV_REM_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic [2:0]       fsm_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    ABS_A = 3'd2,
    ABS_B = 3'd3,
    DIV   = 3'd4,
    FIX   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;   // multiplicand / raw dividend
  logic [WIDTH-1:0] op_b;   // raw divisor, then |divisor|
  logic [WIDTH-1:0] hi;     // product high half / partial remainder
  logic [WIDTH-1:0] lo;     // product low half / quotient
  logic             q_bit;
  logic             sign_a, sign_b, ovf;

  logic             start, last, neg_q, mul_msb, mul_exc;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

  assign fsm_state = state;
  assign start     = ctrl_MULT | ctrl_DIV;
  assign last      = (cnt == CW'(WIDTH - 1));
  assign neg_q     = sign_a ^ sign_b;

  // True sign of the (WIDTH+1)-bit sum, so Booth steps never lose the sign on overflow.
  assign mul_msb  = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;
  assign mul_hi_n = {mul_msb, add_sum[WIDTH-1:1]};
  assign mul_lo_n = {add_sum[0], lo[WIDTH-1:1]};
  assign mul_exc  = (mul_hi_n != {WIDTH{mul_lo_n[WIDTH-1]}});

  always_comb begin
    state_n = state;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      MUL: begin
        add_a = hi;
        case ({lo[0], q_bit})
          2'b01: add_b = op_a;
          2'b10: begin
            add_b   = ~op_a;
            add_cin = 1'b1;
          end
          default: add_b = '0;
        endcase
        if (last) state_n = DONE;
      end
      ABS_A: begin
        add_b   = op_a[WIDTH-1] ? ~op_a : op_a;
        add_cin = op_a[WIDTH-1];
        state_n = ABS_B;
      end
      ABS_B: begin
        add_b   = op_b[WIDTH-1] ? ~op_b : op_b;
        add_cin = op_b[WIDTH-1];
        state_n = DIV;
      end
      DIV: begin
        add_a   = {hi[WIDTH-2:0], lo[WIDTH-1]};
        add_b   = ~op_b;
        add_cin = 1'b1;
        if (last) state_n = FIX;
      end
      FIX: begin
`ifdef MULTDIV_REM_EN
        if (cnt != '0) begin
          add_b   = sign_a ? ~hi : hi;
          add_cin = sign_a;
          state_n = DONE;
        end else begin
          add_b   = neg_q ? ~lo : lo;
          add_cin = neg_q;
        end
`else
        add_b   = neg_q ? ~lo : lo;
        add_cin = neg_q;
        state_n = DONE;
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A new start aborts whatever is in flight; multiply wins a tie.
    if (start) begin
      if (ctrl_MULT)                state_n = MUL;
      else if (data_operandB == '0) state_n = DONE;
      else                          state_n = ABS_A;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      op_a           <= '0;
      op_b           <= '0;
      hi             <= '0;
      lo             <= '0;
      q_bit          <= 1'b0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULTDIV_REM_EN
      data_remainder <= '0;
`endif
    end else begin
      state          <= state_n;
      data_resultRDY <= 1'b0;
      if (start) begin
        op_a   <= data_operandA;
        op_b   <= data_operandB;
        cnt    <= '0;
        hi     <= '0;
        lo     <= ctrl_MULT ? data_operandB : '0;
        q_bit  <= 1'b0;
        sign_a <= data_operandA[WIDTH-1];
        sign_b <= data_operandB[WIDTH-1];
        ovf    <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
        if (!ctrl_MULT && data_operandB == '0) begin
          data_result    <= '0;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
`ifdef MULTDIV_REM_EN
          data_remainder <= '0;
`endif
        end
      end else begin
        case (state)
          MUL: begin
            hi    <= mul_hi_n;
            lo    <= mul_lo_n;
            q_bit <= lo[0];
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) begin
              data_result    <= mul_lo_n;
              data_exception <= mul_exc;
              data_resultRDY <= 1'b1;
            end
          end
          ABS_A: lo   <= add_sum;
          ABS_B: op_b <= add_sum;
          DIV: begin
            // Carry out means shifted remainder >= |divisor|: keep the difference.
            hi  <= add_cout ? add_sum : add_a;
            lo  <= {lo[WIDTH-2:0], add_cout};
            cnt <= last ? '0 : cnt + 1'b1;
          end
          FIX: begin
`ifdef MULTDIV_REM_EN
            if (cnt == '0) begin
              lo  <= add_sum;
              cnt <= CW'(1);
            end else begin
              data_result    <= lo;
              data_remainder <= add_sum;
              data_exception <= ovf;
              data_resultRDY <= 1'b1;
              cnt            <= '0;
            end
`else
            data_result    <= add_sum;
            data_exception <= ovf;
            data_resultRDY <= 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed + random bench for multdiv_ctrl with a behavioural adder and an expected-result queue.
// Build with +define+MULTDIV_REM_EN to also check the remainder and the longer divide latency.
module tb_multdiv_ctrl;

  localparam int W = 32;
`ifdef MULTDIV_REM_EN
  localparam int DIV_LAT = W + 5;
`else
  localparam int DIV_LAT = W + 4;
`endif
  localparam int MUL_LAT = W + 1;

  logic         clock, reset_n, ctrl_MULT, ctrl_DIV;
  logic [W-1:0] data_operandA, data_operandB;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY;
  logic [W-1:0] data_remainder;
  logic [2:0]   fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         exc_q[$];
  logic [W-1:0] rem_q[$];
  int           lat_q[$];
  logic         div_q[$];

  multdiv_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
`ifdef MULTDIV_REM_EN
    .data_remainder(data_remainder),
`endif
    .fsm_state(fsm_state)
  );

`ifndef MULTDIV_REM_EN
  assign data_remainder = '0;
`endif

  // External adder model.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       p;
    int           sa, sb;
    logic [W-1:0] res, rem;
    logic         exc;
    sa = $signed(a);
    sb = $signed(b);
    rem = '0;
    if (mul) begin
      p   = longint'(sa) * longint'(sb);
      res = p[31:0];
      exc = (p[63:32] != {32{p[31]}});
      lat_q.push_back(MUL_LAT);
    end else if (b == '0) begin
      res = '0;
      exc = 1'b1;
      lat_q.push_back(1);
    end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      res = 32'h8000_0000;
      exc = 1'b1;
      lat_q.push_back(DIV_LAT);
    end else begin
      res = sa / sb;
      rem = sa % sb;
      exc = 1'b0;
      lat_q.push_back(DIV_LAT);
    end
    exp_q.push_back(res);
    exc_q.push_back(exc);
    rem_q.push_back(rem);
    div_q.push_back(!mul);
  endtask

  // Called just after a negedge; start pulse covers the current cycle (cycle 0).
  task automatic drive_start(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic start_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    push_exp(m, a, b);
    drive_start(m, d, a, b);
  endtask

  // Entered at cycle 1 of the operation; bounded wait for the ready pulse.
  task automatic wait_result(input string tag);
    int           cyc;
    logic         seen;
    logic [W-1:0] e_res, e_rem;
    logic         e_exc, e_div;
    int           e_lat;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 80 && !seen) begin
      if (data_resultRDY === 1'b1) seen = 1'b1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    e_res = exp_q.pop_front();
    e_exc = exc_q.pop_front();
    e_rem = rem_q.pop_front();
    e_lat = lat_q.pop_front();
    e_div = div_q.pop_front();
    check({tag, "_rdy_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(e_lat));
    check({tag, "_result"}, data_result, e_res);
    check({tag, "_exception"}, {31'b0, data_exception}, {31'b0, e_exc});
`ifdef MULTDIV_REM_EN
    if (e_div) check({tag, "_remainder"}, data_remainder, e_rem);
`else
    if (e_div) check({tag, "_adder_idle"}, add_a | add_b, '0);
`endif
    @(negedge clock);
    check({tag, "_rdy_pulse"}, {31'b0, data_resultRDY}, 32'd0);
    check({tag, "_held_result"}, data_result, e_res);
  endtask

  initial begin
    int           rdy_count;
    logic [W-1:0] ra, rb;
    logic         rm;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("rst_result", data_result, '0);
    check("rst_exception", {31'b0, data_exception}, '0);
    check("rst_rdy", {31'b0, data_resultRDY}, '0);
    check("rst_adder", {add_a ^ add_b, 31'b0, add_cin} == '0 ? '0 : 32'd1, '0);
    check("rst_state", {29'b0, fsm_state}, '0);
    reset_n = 1'b1;
    @(negedge clock);

    start_op(1, 0, 32'd6, 32'd7);               wait_result("mul_6x7");

    // Reset in the middle of a multiply discards it.
    drive_start(1, 0, 32'd9, 32'd9);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_result", data_result, '0);
    check("midrst_exception", {31'b0, data_exception}, '0);
    check("midrst_rdy", {31'b0, data_resultRDY}, '0);
    check("midrst_add_a", add_a, '0);
    check("midrst_add_b", add_b, '0);
    check("midrst_add_cin", {31'b0, add_cin}, '0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_count = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_count++;
    end
    check("midrst_no_rdy", 32'(rdy_count), '0);

    start_op(1, 0, 32'd6, 32'd7);               wait_result("mul_after_rst");
    start_op(1, 0, -32'sd3, 32'd5);             wait_result("mul_neg3x5");
    start_op(1, 0, 32'd65536, 32'd65536);       wait_result("mul_ovf");
    start_op(1, 0, -32'sd65536, 32'd32768);     wait_result("mul_minint");
    start_op(1, 0, 32'h8000_0000, 32'h8000_0000); wait_result("mul_min_sq");
    start_op(0, 1, 32'd100, 32'd7);             wait_result("div_100_7");
    start_op(0, 1, -32'sd100, 32'd7);           wait_result("div_n100_7");
    start_op(0, 1, 32'd100, -32'sd7);           wait_result("div_100_n7");
    start_op(0, 1, 32'd5, 32'd0);               wait_result("div_by_zero");
    start_op(0, 1, 32'h8000_0000, 32'hffff_ffff); wait_result("div_min_m1");
    start_op(0, 1, 32'h8000_0000, 32'd3);       wait_result("div_min_3");

    // Divide aborted at cycle 10 by a multiply: only the multiply reports.
    drive_start(0, 1, 32'd100, 32'd7);
    rdy_count = 0;
    repeat (9) begin
      if (data_resultRDY === 1'b1) rdy_count++;
      @(negedge clock);
    end
    check("abort_no_early_rdy", 32'(rdy_count), '0);
    start_op(1, 0, 32'd6, 32'd7);               wait_result("abort_mul");

    push_exp(1, 32'd6, 32'd7);
    drive_start(1, 1, 32'd6, 32'd7);            wait_result("both_starts");

    for (int i = 0; i < 16; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      start_op(rm, !rm, ra, rb);
      wait_result(rm ? "rand_mul" : "rand_div");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the CPU execute stage.
- Time-shares one external WIDTH-bit carry-lookahead adder, built from the team's 8-bit block-carry cells, through a combinational request/return interface.
- Signed multiply uses radix-2 Booth; signed divide uses restoring division on magnitudes.
- Produces a one-cycle result-ready pulse consumed by the pipeline stall logic.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 8 (adder built from 8-bit blocks)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
ctrl_MULT  in  1  one-cycle start pulse, multiply
ctrl_DIV  in  1  one-cycle start pulse, divide
data_operandA  in  WIDTH  multiplicand / dividend, signed, sampled on start
data_operandB  in  WIDTH  multiplier / divisor, signed, sampled on start
add_a  out  WIDTH  adder operand A
add_b  out  WIDTH  adder operand B (already inverted for subtract)
add_cin  out  1  adder carry-in (1 for subtract/negate)
add_sum  in  WIDTH  adder sum, combinational return same cycle
add_cout  in  1  adder carry-out
data_result  out  WIDTH  signed result, valid while data_resultRDY=1
data_exception  out  1  overflow / divide-by-zero, valid with data_resultRDY
data_resultRDY  out  1  one-cycle result-valid pulse

Behaviour:
- Reset (reset_n=0, async): state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, add_a/add_b/add_cin=0; all internal registers 0.
- States: IDLE, MUL, ABS_A, ABS_B, DIV, FIX, DONE.
- Start: ctrl_MULT or ctrl_DIV sampled in ANY state aborts the current operation, latches operands, clears the counter. Both high in one cycle -> multiply wins.
- Multiply: start -> MUL for exactly WIDTH cycles.
  - Product register {hi, lo, q}, hi=0, lo=B, q=0.
  - Each cycle, {lo[0],q}: 01 -> hi+A; 10 -> hi+~A+1; 00/11 -> hi+0. Result comes through the adder, then an arithmetic right shift of the whole register.
  - Then DONE. data_resultRDY is high at cycle WIDTH+1 after the start cycle (start = cycle 0).
  - data_result = lo.
  - data_exception=1 iff hi is not all copies of lo[WIDTH-1].
- Divide: start -> ABS_A -> ABS_B -> WIDTH DIV cycles -> FIX -> DONE. data_resultRDY is high at cycle WIDTH+4.
  - ABS_A/ABS_B: adder computes 0+~X+1 if X negative, else 0+X; result goes to the magnitude register.
  - DIV step: shift {R,Q} left 1. Adder computes R+~|B|+1. If add_cout=1, R=sum and Q[0]=1; else R is unchanged and Q[0]=0.
  - FIX: if sign(A)^sign(B), Q=0+~Q+1; remainder takes the sign of A, negated in the same cycle via a second pass is not allowed. The remainder sign fix uses FIX's adder only when MULTDIV_REM_EN (see below); otherwise the adder negates Q only.
  - Divisor==0 is detected at start: go directly to DONE next cycle (resultRDY at cycle 1), data_result=0, data_exception=1.
  - Most-negative / -1: data_result=most-negative, data_exception=1.
- DONE lasts one cycle, then IDLE. data_result and data_exception hold until the next start; data_resultRDY is cleared.
- Idle adder drive: add_a=0, add_b=0, add_cin=0.
- Reset asserted mid-operation discards the operation; no resultRDY is emitted.

Optional Feature:
MULTDIV_REM_EN:
- Defined:
  - Adds output data_remainder [WIDTH-1:0], signed with the sign of the dividend.
  - FIX takes 2 cycles (quotient negate, then remainder negate), so divide resultRDY is at cycle WIDTH+5.
  - data_remainder=0 on reset and on divide-by-zero.
- Undefined: port absent, FIX takes 1 cycle, latency as above.

Test Plan:
- reset_n=0 mid-multiply, release -> all outputs 0, no resultRDY, next ctrl_MULT 6*7 works normally.
- ctrl_MULT A=6, B=7 -> resultRDY at cycle 33, result=42, exception=0; A=-3, B=5 -> -15, exception=0.
- ctrl_MULT A=65536, B=65536 -> result=0, exception=1; A=-65536, B=32768 -> result=-2147483648, exception=0.
- ctrl_DIV A=100, B=7 -> result=14 at cycle 36 (37 with REM_EN, remainder=2); A=-100, B=7 -> -14 (remainder -2).
- ctrl_DIV A=5, B=0 -> resultRDY at cycle 1, result=0, exception=1; A=-2147483648, B=-1 -> result=-2147483648, exception=1.
- ctrl_DIV 100/7 started, ctrl_MULT 6*7 at cycle 10 -> single resultRDY at cycle 43 with result 42; ctrl_MULT and ctrl_DIV together -> multiply result.
